// File: rtl/reg_wr_arb.sv
// reg_wr_arb: round-robin arbiter that merges two register-file write requesters and runs a clear sweep
module reg_wr_arb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              busy,
  output logic              we,
  output logic [ADDR_W-1:0] reg_Wt_addr,
  output logic [DATA_W-1:0] wdata
);
  typedef enum logic {ARB, CLEAR} state_t;
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              arb_ok, g0, g1;
  logic [ADDR_W-1:0] sel_addr;
  // Grants: ptr_q=0 favours requester 0 on contention; clear and reset suppress all grants
  always_comb begin
    arb_ok   = !rst && state_q == ARB && !clr_start;
    g0       = arb_ok && req0_valid && (!req1_valid || !ptr_q);
    g1       = arb_ok && req1_valid && (!req0_valid || ptr_q);
    sel_addr = g1 ? req1_addr : req0_addr;
  end
  // Next state: clear sweep, clear entry, or accept the granted write (address 0 is dropped)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (state_q == CLEAR) begin
      we_d    = 1'b1;
      addr_d  = ADDR_W'(cnt_q);
      data_d  = '0;
      cnt_d   = (cnt_q == 5'd31) ? 5'd0 : cnt_q + 5'd1;
      state_d = (cnt_q == 5'd31) ? ARB : CLEAR;
    end else if (clr_start) begin
      state_d = CLEAR;
      cnt_d   = 5'd1;
    end else if (g0 || g1) begin
      ptr_d  = g0;
      we_d   = sel_addr != '0;
      addr_d = (sel_addr != '0) ? sel_addr : addr_q;
      data_d = (sel_addr != '0) ? (g1 ? req1_data : req0_data) : data_q;
    end
  end
  // State and write-port registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign req0_ready  = g0;
  assign req1_ready  = g1;
  assign busy        = state_q == CLEAR;
  assign we          = we_q;
  assign reg_Wt_addr = addr_q;
  assign wdata       = data_q;
endmodule

// File: tb/tb_reg_wr_arb.sv
// tb_reg_wr_arb: directed and random checks of reg_wr_arb against a behavioural write-port model
module tb_reg_wr_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, r0, r1, clr, busy, we;
  logic [4:0]  a0, a1, wa;
  logic [31:0] d0, d1, wd;
  int          n_checks = 0;
  int          n_fail = 0;
  int          clear_left, fav, g_last;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          grants[4];

  reg_wr_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .clr_start(clr), .busy(busy), .we(we), .reg_Wt_addr(wa), .wdata(wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clear_left = 0;
    fav = 0;
    g_last = -1;
    exp_we = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic step();
    logic e0, e1;
    logic [4:0] aa;
    @(negedge clk);
    e0 = !rst && clear_left == 0 && !clr && v0 && (!v1 || fav == 0);
    e1 = !rst && clear_left == 0 && !clr && v1 && (!v0 || fav == 1);
    chk("ready0", 64'(r0), 64'(e0));
    chk("ready1", 64'(r1), 64'(e1));
    chk("one_ready", 64'(r0 & r1), 64'd0);
    chk("busy", 64'(busy), 64'(clear_left > 0));
    chk("we", 64'(we), 64'(exp_we));
    chk("addr", 64'(wa), 64'(exp_addr));
    chk("wdata", 64'(wd), 64'(exp_data));
    if (rst) model_reset();
    else begin
      g_last = e0 ? 0 : e1 ? 1 : -1;
      if (clear_left > 0) begin
        exp_we = 1'b1;
        exp_addr = 5'(32 - clear_left);
        exp_data = '0;
        clear_left--;
      end else if (clr) begin
        clear_left = 31;
        exp_we = 1'b0;
      end else if (g_last >= 0) begin
        fav = 1 - g_last;
        aa = (g_last == 1) ? a1 : a0;
        exp_we = aa != 0;
        if (aa != 0) begin
          exp_addr = aa;
          exp_data = (g_last == 1) ? d1 : d0;
        end
      end else exp_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; clr = 0;
    model_reset();
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(wa), 64'd0);
    chk("rst_ready", 64'({r0, r1}), 64'd0);
    step();
    rst = 1'b0;
    // single write
    v0 = 1; a0 = 5; d0 = 32'hA5A5A5A5;
    step();
    v0 = 0;
    chk("w1_we", 64'(we), 64'd1);
    chk("w1_addr", 64'(wa), 64'd5);
    chk("w1_data", 64'(wd), 64'hA5A5A5A5);
    step();
    chk("w1_we_off", 64'(we), 64'd0);
    // contention from a fresh pointer
    do_reset();
    v0 = 1; a0 = 5; d0 = 32'h11111111;
    v1 = 1; a1 = 6; d1 = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      step();
      grants[i] = g_last;
      chk("rr_addr", 64'(wa), (i % 2 == 0) ? 64'd5 : 64'd6);
    end
    for (int i = 0; i < 4; i++) chk("rr_grant", 64'(grants[i]), 64'(i % 2));
    v0 = 0; v1 = 0;
    step();
    // write to address 0 is dropped
    v1 = 1; a1 = 0; d1 = 32'hAAAA5555;
    step();
    v1 = 0;
    chk("a0_we", 64'(we), 64'd0);
    step();
    // clear with requester 0 waiting
    v0 = 1; a0 = 9; d0 = 32'h12345678; clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 31; i++) step();
    chk("clr_last_addr", 64'(wa), 64'd31);
    step();
    chk("clr_after_grant", 64'(g_last), 64'd0);
    v0 = 0;
    step();
    // reset in the middle of a clear
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_we", 64'(we), 64'd0);
    chk("arst_addr", 64'(wa), 64'd0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    // full sweep: fill, clear, then a single write
    for (int i = 1; i < 32; i++) begin
      v0 = 1; a0 = 5'(i); d0 = 32'(i);
      step();
    end
    v0 = 0; clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 31; i++) step();
    v0 = 1; a0 = 7; d0 = 32'h7;
    step();
    v0 = 0;
    for (int i = 0; i < 3; i++) step();
    // random traffic, requesters hold addr/data until accepted
    for (int i = 0; i < 500; i++) begin
      if (g_last == 0 || !v0) begin
        v0 = 1'($urandom); a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); d0 = $urandom;
      end
      if (g_last == 1 || !v1) begin
        v1 = 1'($urandom); a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); d1 = $urandom;
      end
      clr = $urandom_range(0, 59) == 0;
      step();
    end
    clr = 0; v0 = 0; v1 = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width; fixed to match the 32-entry register file.
REQ-002 Parameter DATA_W, default 32, write-data width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has a write pending.
REQ-006 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 req0_data  input  DATA_W  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 write accepted this cycle (combinational).
REQ-009 req1_valid, req1_addr, req1_data, req1_ready  same directions/widths/meanings as REQ-005..008, for requester 1.
REQ-010 clr_start  input  1  one-cycle request to zero registers 1..31.
REQ-011 busy  output  1  high while clear sequence runs.
REQ-012 we  output  1  registered write enable to register file.
REQ-013 reg_Wt_addr  output  ADDR_W  registered write address to register file.
REQ-014 wdata  output  DATA_W  registered write data to register file.

Function
REQ-015 States SHALL be ARB and CLEAR; busy SHALL equal (state==CLEAR).
REQ-016 Handshake: transfer on reqN_valid & reqN_ready at a rising edge; requester SHALL hold addr/data stable until transfer.
REQ-017 In ARB with clr_start=0, exactly one ready SHALL assert when any valid is high; at most one ready per cycle ever.
REQ-018 Only one valid high -> that requester's ready SHALL assert.
REQ-019 Both valid -> grant SHALL go to the requester not granted last (round-robin pointer); pointer SHALL update on every transfer.
REQ-020 Accepted transfer at edge N SHALL set we=1, reg_Wt_addr=addr, wdata=data from edge N until edge N+1 (one-cycle latency, one write per cycle, back-to-back allowed).
REQ-021 Transfer with addr==0 SHALL complete the handshake and update the pointer but SHALL register we=0 (write dropped).
REQ-022 Cycle with no transfer and not CLEAR SHALL register we=0; reg_Wt_addr/wdata SHALL hold previous value.
REQ-023 clr_start=1 in ARB SHALL force both ready=0 that cycle (clear has priority) and enter CLEAR at the next edge with counter=1.
REQ-024 In CLEAR both ready SHALL be 0; each edge SHALL register we=1, reg_Wt_addr=counter, wdata=0, then increment counter.
REQ-025 Edge registering counter==31 SHALL return to ARB; CLEAR lasts exactly 31 cycles; 31 consecutive we pulses to addresses 1..31.
REQ-026 clr_start during CLEAR SHALL be ignored (no restart, no extension).
REQ-027 Requests pending during CLEAR SHALL be served normally from the first ARB cycle; the round-robin pointer SHALL be unchanged by CLEAR.
REQ-028 Counter SHALL be 5 bits and never wrap past 31 within a sequence.

Reset
REQ-029 rst=1 SHALL immediately, without clk, force state=ARB, counter=0, pointer favouring requester 0, we=0, reg_Wt_addr=0, wdata=0, busy=0.
REQ-030 While rst=1 both ready SHALL be 0.
REQ-031 rst asserted mid-CLEAR SHALL abort the sequence; after release the block SHALL sit in ARB with no residual writes.

Verification
REQ-032 Reset then req0_valid=1, addr=5, data=A5A5A5A5 one cycle -> req0_ready=1; next cycle we=1, reg_Wt_addr=5, wdata=A5A5A5A5; following cycle we=0.
REQ-033 Both valid continuously (req0 addr 5/data 11111111, req1 addr 6/data 22222222) for 4 cycles -> grants 0,1,0,1; we high 4 cycles with addresses 5,6,5,6.
REQ-034 req1_valid=1, addr=0, data=AAAA5555 -> req1_ready=1, we stays 0 next cycle.
REQ-035 clr_start pulse with req0_valid=1 held -> req0_ready=0 for 32 cycles, busy=1 for 31 cycles, we=1 with addresses 1..31 and wdata=0, then req0 granted on first ARB cycle.
REQ-036 rst asserted between clock edges after 10 clear writes -> busy, we, reg_Wt_addr drop to 0 immediately; after release no further clear writes.
REQ-037 Full sweep: write 1..31 with data = address, clear, then write only addr 7 -> we pulses observed in exact order, no two ready high in any cycle.
